// File: rtl/scc_ctrl_fsm.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for the scc core.
// Optional single-step mode is enabled by defining SCC_CTRL_SINGLE_STEP_EN.
module scc_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RET_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             start,
`ifdef SCC_CTRL_SINGLE_STEP_EN
    input  logic             step_mode,
`endif
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             dec_illegal,
    input  logic             dec_halt,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             dec_wr_rd,
    input  logic             dec_set_flags,
    input  logic             addr_misaligned,
    output logic             instruction_memory_en,
    output logic             ir_load,
    output logic             data_memory_en,
    output logic             data_memory_we,
    output logic             pstate_write,
    output logic             reg_write,
    output logic             pc_write,
    output logic             pc_src_branch,
    output logic             halted,
    output logic [3:0]       err_bits,
    output logic [2:0]       state,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StFetch     = 3'd1,
        StDecode    = 3'd2,
        StExecute   = 3'd3,
        StMemory    = 3'd4,
        StWriteback = 3'd5,
        StHalt      = 3'd6,
        StError     = 3'd7
    } state_e;

    localparam logic [7:0] WaitLast = 8'(MEM_TIMEOUT - 1);

    state_e           state_q;
    logic [7:0]       wait_q;
    logic             load_q;
    logic             store_q;
    logic             branch_q;
    logic             wr_rd_q;
    logic             set_flags_q;
    logic [3:0]       err_q;
    logic [RET_W-1:0] retired_q;
    logic             step_stop;

`ifdef SCC_CTRL_SINGLE_STEP_EN
    assign step_stop = step_mode;
`else
    assign step_stop = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            load_q      <= 1'b0;
            store_q     <= 1'b0;
            branch_q    <= 1'b0;
            wr_rd_q     <= 1'b0;
            set_flags_q <= 1'b0;
            err_q       <= '0;
            retired_q   <= '0;
        end else if (clk_en) begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StFetch;
                        wait_q  <= '0;
                    end
                end
                StFetch: begin
                    // Ready on the last allowed cycle still wins over the timeout.
                    if (imem_ready) begin
                        state_q <= StDecode;
                    end else if (wait_q == WaitLast) begin
                        state_q  <= StError;
                        err_q[0] <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StDecode: begin
                    load_q      <= dec_load;
                    store_q     <= dec_store;
                    branch_q    <= dec_branch;
                    wr_rd_q     <= dec_wr_rd;
                    set_flags_q <= dec_set_flags;
                    if (dec_illegal) begin
                        state_q  <= StError;
                        err_q[1] <= 1'b1;
                    end else if (dec_halt) begin
                        state_q <= StHalt;
                    end else begin
                        state_q <= StExecute;
                    end
                end
                StExecute: begin
                    if ((load_q || store_q) && addr_misaligned) begin
                        state_q  <= StError;
                        err_q[3] <= 1'b1;
                    end else if (load_q || store_q) begin
                        state_q <= StMemory;
                        wait_q  <= '0;
                    end else begin
                        state_q <= StWriteback;
                    end
                end
                StMemory: begin
                    if (dmem_ready) begin
                        state_q <= StWriteback;
                    end else if (wait_q == WaitLast) begin
                        state_q  <= StError;
                        err_q[2] <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                StWriteback: begin
                    retired_q <= retired_q + RET_W'(1);
                    wait_q    <= '0;
                    state_q   <= step_stop ? StIdle : StFetch;
                end
                StHalt:  state_q <= StHalt;
                StError: state_q <= StError;
                default: state_q <= StError;
            endcase
        end
    end

    // Strobes are qualified by clk_en; request levels follow the state alone.
    always_comb begin
        instruction_memory_en = (state_q == StFetch);
        ir_load               = (state_q == StFetch) && imem_ready && clk_en;
        data_memory_en        = (state_q == StMemory);
        data_memory_we        = (state_q == StMemory) && store_q;
        pstate_write          = (state_q == StExecute) && set_flags_q && clk_en;
        reg_write             = (state_q == StWriteback) && wr_rd_q && !store_q && clk_en;
        pc_write              = (state_q == StWriteback) && clk_en;
        pc_src_branch         = branch_q;
        halted                = (state_q == StHalt);
        err_bits              = err_q;
        state                 = state_q;
        retired               = retired_q;
    end

endmodule
